// File: rtl/vehicle_pkg.sv
// Shared types and default thresholds for the vehicle status front end.
package vehicle_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVING = 2'd1,
    ARRIVED = 2'd2
  } trip_state_t;

  localparam int TEMP_HOT_DEF   = 85;
  localparam int TEMP_COOL_DEF  = 70;
  localparam int FUEL_EMPTY_DEF = 4;
  localparam int FUEL_OK_DEF    = 12;
  localparam int DEBOUNCE_DEF   = 4;

endpackage

// File: rtl/hyst_debounce.sv
// Debounced hysteresis flag: DEBOUNCE consecutive qualifying valid samples
// toggle the flag; set_cond qualifies while low, clr_cond while high.
module hyst_debounce #(
  parameter int   DEBOUNCE   = 4,
  parameter logic RESET_FLAG = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid,
  input  logic set_cond,
  input  logic clr_cond,
  output logic flag
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;
  logic          qual;

  // The condition that counts toward a change depends on the current flag.
  assign qual = flag ? clr_cond : set_cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= RESET_FLAG;
    end else if (sample_valid) begin
      if (!qual) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        cnt  <= '0;
        flag <= ~flag;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vehicle_status_monitor.sv
// Sensor front end: debounced overheat / fuel-empty flags and a trip FSM
// that counts odometer ticks down from a loaded destination distance.
module vehicle_status_monitor
  import vehicle_pkg::*;
#(
  parameter int TEMP_W     = 8,
  parameter int TEMP_HOT   = TEMP_HOT_DEF,
  parameter int TEMP_COOL  = TEMP_COOL_DEF,
  parameter int FUEL_W     = 8,
  parameter int FUEL_EMPTY = FUEL_EMPTY_DEF,
  parameter int FUEL_OK    = FUEL_OK_DEF,
  parameter int DIST_W     = 16,
  parameter int DEBOUNCE   = DEBOUNCE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_c,
  input  logic              fuel_valid,
  input  logic [FUEL_W-1:0] fuel_level,
  input  logic              dest_load,
  input  logic [DIST_W-1:0] dest_dist,
  input  logic              odo_tick,
  output logic              cpu_overheated,
  output logic              gas_tank_empty,
  output logic              arrived,
  output logic [DIST_W-1:0] remaining
);

  logic temp_hot, temp_cool, fuel_low, fuel_ok;

  assign temp_hot  = temp_c     >= TEMP_W'(TEMP_HOT);
  assign temp_cool = temp_c     <= TEMP_W'(TEMP_COOL);
  assign fuel_low  = fuel_level <= FUEL_W'(FUEL_EMPTY);
  assign fuel_ok   = fuel_level >= FUEL_W'(FUEL_OK);

  hyst_debounce #(.DEBOUNCE(DEBOUNCE), .RESET_FLAG(1'b0)) u_temp_filt (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (temp_valid),
    .set_cond     (temp_hot),
    .clr_cond     (temp_cool),
    .flag         (cpu_overheated)
  );

  // Fuel starts flagged empty so nothing drives until a level is confirmed.
  hyst_debounce #(.DEBOUNCE(DEBOUNCE), .RESET_FLAG(1'b1)) u_fuel_filt (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (fuel_valid),
    .set_cond     (fuel_low),
    .clr_cond     (fuel_ok),
    .flag         (gas_tank_empty)
  );

  trip_state_t       state, state_nxt;
  logic [DIST_W-1:0] rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      arrived   <= 1'b1;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
      arrived   <= (state_nxt != DRIVING);
    end
  end

  // A load overrides a coincident tick; ticks outside DRIVING are dropped.
  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    if (dest_load) begin
      rem_nxt   = dest_dist;
      state_nxt = (dest_dist != '0) ? DRIVING : ARRIVED;
    end else if (state == DRIVING && odo_tick) begin
      if (remaining <= DIST_W'(1)) begin
        rem_nxt   = '0;
        state_nxt = ARRIVED;
      end else begin
        rem_nxt = remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vehicle_status_monitor.sv
// Directed self-checking bench for vehicle_status_monitor.
module tb_vehicle_status_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        temp_valid, fuel_valid, dest_load, odo_tick;
  logic [7:0]  temp_c, fuel_level;
  logic [15:0] dest_dist;
  logic        cpu_overheated, gas_tank_empty, arrived;
  logic [15:0] remaining;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vehicle_status_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .temp_valid     (temp_valid),
    .temp_c         (temp_c),
    .fuel_valid     (fuel_valid),
    .fuel_level     (fuel_level),
    .dest_load      (dest_load),
    .dest_dist      (dest_dist),
    .odo_tick       (odo_tick),
    .cpu_overheated (cpu_overheated),
    .gas_tank_empty (gas_tank_empty),
    .arrived        (arrived),
    .remaining      (remaining)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one edge, settle, then drop all strobes.
  task automatic step();
    @(posedge clk);
    #1;
    temp_valid = 1'b0;
    fuel_valid = 1'b0;
    dest_load  = 1'b0;
    odo_tick   = 1'b0;
  endtask

  task automatic send_temp(input int v);
    temp_valid = 1'b1;
    temp_c     = 8'(v);
    step();
  endtask

  task automatic send_fuel(input int v);
    fuel_valid = 1'b1;
    fuel_level = 8'(v);
    step();
  endtask

  task automatic load(input int d, input logic tick);
    dest_load = 1'b1;
    dest_dist = 16'(d);
    odo_tick  = tick;
    step();
  endtask

  task automatic tick();
    odo_tick = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    temp_valid = 0; fuel_valid = 0; dest_load = 0; odo_tick = 0;
    temp_c = 0; fuel_level = 0; dest_dist = 0;
    #23 rst_n = 1'b1;
    step(); step();

    // reset values
    chk("rst_ovh", cpu_overheated, 0);
    chk("rst_empty", gas_tank_empty, 1);
    chk("rst_arrived", arrived, 1);
    chk("rst_remaining", remaining, 0);

    // overheat set after 4th consecutive hot sample
    for (int i = 0; i < 4; i++) begin
      send_temp(90);
      chk("ovh_set", cpu_overheated, (i == 3) ? 1 : 0);
    end
    // clear with 4 samples at TEMP_COOL
    for (int i = 0; i < 4; i++) begin
      send_temp(70);
      chk("ovh_clr", cpu_overheated, (i == 3) ? 0 : 1);
    end
    // broken run: 80 lies between thresholds
    send_temp(90); send_temp(90); send_temp(80); send_temp(90);
    chk("ovh_broken", cpu_overheated, 0);
    send_temp(80);
    // hot samples separated by non-valid gaps still count
    for (int i = 0; i < 4; i++) begin
      send_temp(90);
      step(); step();
      chk("ovh_gaps", cpu_overheated, (i == 3) ? 1 : 0);
    end
    // 71 is above the clear threshold: flag holds
    for (int i = 0; i < 4; i++) send_temp(71);
    chk("ovh_hold71", cpu_overheated, 1);
    for (int i = 0; i < 4; i++) send_temp(70);
    chk("ovh_clr2", cpu_overheated, 0);

    // fuel: clear from reset-empty, hold, set, hold, clear
    for (int i = 0; i < 4; i++) begin
      send_fuel(12);
      chk("fuel_clr", gas_tank_empty, (i == 3) ? 0 : 1);
    end
    for (int i = 0; i < 4; i++) send_fuel(8);
    chk("fuel_hold0", gas_tank_empty, 0);
    for (int i = 0; i < 4; i++) begin
      send_fuel(4);
      chk("fuel_set", gas_tank_empty, (i == 3) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) send_fuel(8);
    chk("fuel_hold1", gas_tank_empty, 1);
    send_fuel(12); send_fuel(12); send_fuel(13); send_fuel(12);
    chk("fuel_clr2", gas_tank_empty, 0);

    // trip FSM
    tick();
    chk("idle_tick_rem", remaining, 0);
    chk("idle_tick_arr", arrived, 1);
    load(3, 1'b0);
    chk("load3_rem", remaining, 3);
    chk("load3_arr", arrived, 0);
    tick(); chk("tick1_rem", remaining, 2); chk("tick1_arr", arrived, 0);
    tick(); chk("tick2_rem", remaining, 1); chk("tick2_arr", arrived, 0);
    tick(); chk("tick3_rem", remaining, 0); chk("tick3_arr", arrived, 1);
    tick(); chk("extra_tick_rem", remaining, 0); chk("extra_tick_arr", arrived, 1);
    load(0, 1'b0);
    chk("load0_arr", arrived, 1);
    chk("load0_rem", remaining, 0);
    load(5, 1'b1);
    chk("load_tick_rem", remaining, 5);
    chk("load_tick_arr", arrived, 0);
    tick();
    chk("tick_after5", remaining, 4);

    // asynchronous reset mid-trip, checked before any clock edge
    rst_n = 1'b0;
    #2;
    chk("arst_arr", arrived, 1);
    chk("arst_rem", remaining, 0);
    chk("arst_empty", gas_tank_empty, 1);
    #3 rst_n = 1'b1;
    step();
    load(2, 1'b0);
    chk("resume_rem", remaining, 2);
    chk("resume_arr", arrived, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vehicle_status_monitor.md
# vehicle_status_monitor

Sensor-side front end that produces the `cpu_overheated`, `gas_tank_empty` and `arrived` status flags consumed by the vehicle control logic. It turns raw, noisy sensor samples into stable, registered flags:
- temperature and fuel level go through debounced hysteresis filters;
- arrival comes from a trip state machine that counts odometer ticks down from a loaded destination distance.

## Interface
- `TEMP_W`, 8: temperature sample width (unsigned °C)
- `TEMP_HOT`, 85: overheat set threshold (sample ≥ TEMP_HOT)
- `TEMP_COOL`, 70: overheat clear threshold (sample ≤ TEMP_COOL); must be < TEMP_HOT
- `FUEL_W`, 8: fuel level sample width (unsigned)
- `FUEL_EMPTY`, 4: empty set threshold (level ≤ FUEL_EMPTY)
- `FUEL_OK`, 12: empty clear threshold (level ≥ FUEL_OK); must be > FUEL_EMPTY
- `DIST_W`, 16: destination/remaining distance width
- `DEBOUNCE`, 4: consecutive qualifying samples needed to change a flag; ≥ 1
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `temp_valid` in 1: `temp_c` holds a new sample this cycle
- `temp_c` in TEMP_W: temperature sample
- `fuel_valid` in 1: `fuel_level` holds a new sample this cycle
- `fuel_level` in FUEL_W: fuel level sample
- `dest_load` in 1: single-cycle strobe; start a new trip of `dest_dist` units
- `dest_dist` in DIST_W: trip length, sampled when `dest_load`=1
- `odo_tick` in 1: single-cycle pulse, one per distance unit travelled
- `cpu_overheated` out 1: debounced overheat flag
- `gas_tank_empty` out 1: debounced fuel-empty flag
- `arrived` out 1: high when no trip is in progress
- `remaining` out DIST_W: distance units left in the current trip

## Operation
- All outputs are registered.
- Reset values:
  - `cpu_overheated`=0
  - `gas_tank_empty`=1 (fail-safe: no driving until fuel is confirmed)
  - `arrived`=1
  - `remaining`=0
  - FSM in IDLE
  - debounce counters at 0
- Hysteresis filter, one instance per flag:
  - Set condition: overheat when sample ≥ TEMP_HOT; empty when level ≤ FUEL_EMPTY.
  - Clear condition: overheat when sample ≤ TEMP_COOL; empty when level ≥ FUEL_OK.
  - Cycles with valid=0 leave the counter and flag unchanged.
  - Flag=0: each valid sample meeting the set condition increments the counter; any other valid sample zeroes it. When the counter reaches DEBOUNCE, the flag sets and the counter zeroes.
  - Flag=1: same behaviour, using the clear condition.
  - Samples strictly between the thresholds zero the counter and hold the flag.
  - Counter width is $clog2(DEBOUNCE+1). The counter never exceeds DEBOUNCE.
- Trip FSM, states IDLE, DRIVING, ARRIVED:
  - `dest_load` in any state: `remaining` ← `dest_dist`. Next state is DRIVING if `dest_dist` ≠ 0, else ARRIVED.
  - DRIVING with `odo_tick`: `remaining` decrements. When `remaining`=1, it becomes 0 and the FSM moves to ARRIVED.
  - `odo_tick` in IDLE or ARRIVED is ignored. `remaining` never wraps below 0.
  - `dest_load` together with `odo_tick` in the same cycle: the load wins and the tick is dropped.
  - `arrived` = (next state ≠ DRIVING), registered.
- No output depends combinationally on any input.

## Timing
- Flag change: the output updates on the clock edge that samples the DEBOUNCE-th consecutive qualifying valid sample. It is visible the cycle after that sample is presented.
- `dest_load` at edge N: `remaining`=`dest_dist` and `arrived`=0 after edge N (`arrived`=1 if `dest_dist`=0).
- Final `odo_tick` at edge N: `remaining`=0 and `arrived`=1 after edge N.
- `rst_n` low mid-trip or mid-debounce: all state returns to reset values immediately (asynchronous). Operation resumes on the first rising edge after deassertion.

## Structure
- Package `vehicle_pkg`:
  - `trip_state_t` enum {IDLE, DRIVING, ARRIVED}
  - default threshold localparams `TEMP_HOT_DEF`, `TEMP_COOL_DEF`, `FUEL_EMPTY_DEF`, `FUEL_OK_DEF`, `DEBOUNCE_DEF`
- Sub-module `hyst_debounce`:
  - parameters: DEBOUNCE, RESET_FLAG
  - inputs: `sample_valid`, `set_cond`, `clr_cond`
  - output: `flag`
  - Instantiated twice. The top computes the threshold compares.
- Trip FSM and distance counter live in the top module.

## Test plan
1. Reset values: reset, then idle → `cpu_overheated`=0, `gas_tank_empty`=1, `arrived`=1, `remaining`=0.
2. Overheat set: DEBOUNCE=4; valid temps 90,90,90 → flag stays 0; 4th 90 → flag=1 the next cycle.
3. Broken run and non-valid gaps: 90,90,80,90 → flag stays 0 (80 lies between thresholds). Gaps with `temp_valid`=0 between four 90s → flag sets.
4. Overheat clear: from flag=1, four samples of 70 → flag=0. Four samples of 71 → flag stays 1.
5. Fuel filter: four levels of 4 → `gas_tank_empty`=0→1 path checked from a cleared state. Four levels of 12 → clears. Levels of 8 hold the flag.
6. Trip FSM:
   - `dest_load` with `dest_dist`=3 → `arrived`=0, `remaining`=3; three `odo_tick`s → `remaining`=0, `arrived`=1; a further tick leaves `remaining`=0.
   - `dest_dist`=0 → `arrived` stays 1.
   - `dest_load`(5) coinciding with a tick → `remaining`=5.
   - `rst_n` pulsed mid-trip → `arrived`=1 immediately.
